// File: rtl/serial_demux_pkg.sv
// -----------------------------------------------------------------------------
// serial_demux_pkg
//
// Shared types and constants for the serial frame demultiplexer and the
// seven-segment display helpers.
//
// Contents:
//   state_t      - frame FSM states (PARITY is only reachable when the design
//                  is built with PARITY_EN defined)
//   SSD_DIGITS   - active-low segment patterns for hex digits 0-F,
//                  bit order {g,f,e,d,c,b,a}
//   ssd_lookup() - hex digit to segment pattern
// -----------------------------------------------------------------------------
package serial_demux_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ADDR   = 3'd1,
        LEN    = 3'd2,
        DATA   = 3'd3,
        PARITY = 3'd4,
        DONE   = 3'd5
    } state_t;

    // A segment lights when its bit is 0.
    localparam logic [6:0] SSD_DIGITS [16] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000,  // 9
        7'b0001000,  // A
        7'b0000011,  // b
        7'b1000110,  // C
        7'b0100001,  // d
        7'b0000110,  // E
        7'b0001110   // F
    };

    function automatic logic [6:0] ssd_lookup(input logic [3:0] value);
        return SSD_DIGITS[value];
    endfunction

endpackage

// File: rtl/hex_to_ssd.sv
// -----------------------------------------------------------------------------
// hex_to_ssd
//
// Purely combinational hex digit to seven-segment decoder. It is shared by
// several display blocks, so it carries no clock or reset.
//
// Ports:
//   hex  in   4  digit value 0-F
//   seg  out  7  active-low segments, order {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module hex_to_ssd
    import serial_demux_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = ssd_lookup(hex);

endmodule

// File: rtl/serial_demux_ssd.sv
// -----------------------------------------------------------------------------
// serial_demux_ssd
//
// Serial frame demultiplexer. A frame arrives MSB first on SerIn as
//   start bit (0), ADDR_W address bits, LEN_W length bits, L payload bits
// and, when built with PARITY_EN defined, one trailing even-parity bit that
// covers the address, length and payload bits.
// Payload bits are forwarded combinationally to ch_out[addr]. One frame bit
// is consumed on each rising clock edge where the clkPB strobe is high;
// with clkPB low everything holds. The remaining payload count is shown as a
// hex digit on ssd_result (low nibble of the length register).
//
// Build option:
//   PARITY_EN  adds the PARITY state and the parity_err output
//
// Parameters:
//   ADDR_W  channel address width, NUM_CH = 2**ADDR_W channels
//   LEN_W   payload length field width, up to 2**LEN_W-1 payload bits
//
// Ports:
//   clock        in   1       system clock, rising edge
//   reset        in   1       asynchronous active-low reset
//   clkPB        in   1       step enable from the debouncer
//   SerIn        in   1       serial frame input
//   ch_out       out  NUM_CH  demuxed data, only the addressed bit is live
//   SerOutValid  out  1       high while payload bits are routed
//   done         out  1       frame complete
//   busy         out  1       high in any state other than IDLE
//   ch_sel       out  ADDR_W  channel address of the current/last frame
//   ssd_result   out  7       remaining payload count, active-low segments
//   parity_err   out  1       (PARITY_EN only) parity check result of the
//                             last frame, valid while done is high
// -----------------------------------------------------------------------------
module serial_demux_ssd
    import serial_demux_pkg::*;
#(
    parameter  int ADDR_W = 2,
    parameter  int LEN_W  = 4,
    localparam int NUM_CH = 2 ** ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clkPB,
    input  logic              SerIn,
    output logic [NUM_CH-1:0] ch_out,
    output logic              SerOutValid,
    output logic              done,
    output logic              busy,
    output logic [ADDR_W-1:0] ch_sel,
    output logic [6:0]        ssd_result
`ifdef PARITY_EN
    ,
    output logic              parity_err
`endif
);

    // The bit counter walks through whichever header field is wider.
    localparam int FIELD_MAX = (ADDR_W > LEN_W) ? ADDR_W : LEN_W;
    localparam int CNT_W     = $clog2(FIELD_MAX + 1);

    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] LEN_LAST  = CNT_W'(LEN_W - 1);

    // Where the frame goes once the payload is exhausted (or was empty).
`ifdef PARITY_EN
    localparam state_t PAYLOAD_END = PARITY;
`else
    localparam state_t PAYLOAD_END = DONE;
`endif

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic [CNT_W-1:0]  cnt;

    // Register values after shifting in the current SerIn bit.
    logic [ADDR_W-1:0] addr_shift;
    logic [LEN_W-1:0]  len_shift;
    logic [3:0]        len_nibble;

    assign addr_shift = ADDR_W'({addr, SerIn});
    assign len_shift  = LEN_W'({len, SerIn});
    assign len_nibble = 4'(len);

`ifdef PARITY_EN
    logic parity_acc;
    logic parity_err_q;
`endif

    // -------------------------------------------------------------------------
    // Next-state and output decode
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // can leave one unassigned and infer a latch.
        state_next  = state;
        SerOutValid = 1'b0;
        ch_out      = '0;
        done        = 1'b0;

        if (clkPB) begin
            case (state)
                IDLE:   if (!SerIn) state_next = ADDR;
                ADDR:   if (cnt == ADDR_LAST) state_next = LEN;
                LEN: begin
                    if (cnt == LEN_LAST) begin
                        state_next = (len_shift == '0) ? PAYLOAD_END : DATA;
                    end
                end
                // The step that consumes the last payload bit takes len to 0.
                DATA:   if (len == LEN_W'(1)) state_next = PAYLOAD_END;
                PARITY: state_next = DONE;
                DONE:   state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end

        case (state)
            DATA: begin
                SerOutValid  = 1'b1;
                ch_out[addr] = SerIn;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    assign busy   = (state != IDLE);
    assign ch_sel = addr;

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            addr  <= '0;
            len   <= '0;
            cnt   <= '0;
        end else if (clkPB) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of its inputs.
            state <= state_next;
            case (state)
                IDLE: cnt <= '0;
                ADDR: begin
                    addr <= addr_shift;
                    cnt  <= (cnt == ADDR_LAST) ? '0 : cnt + CNT_W'(1);
                end
                LEN: begin
                    len <= len_shift;
                    cnt <= (cnt == LEN_LAST) ? '0 : cnt + CNT_W'(1);
                end
                DATA:    len <= len - LEN_W'(1);
                default: ;
            endcase
        end
    end

`ifdef PARITY_EN
    // Even parity: the XOR of all covered bits and the parity bit must be 0.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            parity_acc   <= 1'b0;
            parity_err_q <= 1'b0;
        end else if (clkPB) begin
            case (state)
                IDLE:             parity_acc   <= 1'b0;
                ADDR, LEN, DATA:  parity_acc   <= parity_acc ^ SerIn;
                PARITY:           parity_err_q <= parity_acc ^ SerIn;
                DONE:             parity_err_q <= 1'b0;
                default: ;
            endcase
        end
    end

    assign parity_err = parity_err_q;
`endif

    // -------------------------------------------------------------------------
    // Remaining-count display
    // -------------------------------------------------------------------------
    hex_to_ssd u_hex_to_ssd (
        .hex (len_nibble),
        .seg (ssd_result)
    );

endmodule

// File: tb/tb_serial_demux_ssd.sv
// -----------------------------------------------------------------------------
// tb_serial_demux_ssd
//
// Self-checking bench for serial_demux_ssd (ADDR_W=2, LEN_W=4). Expected
// payload beats are queued when a frame is sent and popped by a monitor that
// samples 2 ns after each falling clock edge. Compile with PARITY_EN defined
// to exercise the parity build.
// -----------------------------------------------------------------------------
module tb_serial_demux_ssd;

    localparam int ADDR_W = 2;
    localparam int LEN_W  = 4;
    localparam int NUM_CH = 4;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              clkPB = 1'b0;
    logic              SerIn = 1'b1;
    logic [NUM_CH-1:0] ch_out;
    logic              SerOutValid;
    logic              done;
    logic              busy;
    logic [ADDR_W-1:0] ch_sel;
    logic [6:0]        ssd_result;
`ifdef PARITY_EN
    logic              parity_err;
`endif

    serial_demux_ssd #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .clkPB       (clkPB),
        .SerIn       (SerIn),
        .ch_out      (ch_out),
        .SerOutValid (SerOutValid),
        .done        (done),
        .busy        (busy),
        .ch_sel      (ch_sel),
        .ssd_result  (ssd_result)
`ifdef PARITY_EN
        ,
        .parity_err  (parity_err)
`endif
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Independent segment reference, active-low {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0:  return 7'b1000000;
            1:  return 7'b1111001;
            2:  return 7'b0100100;
            3:  return 7'b0110000;
            4:  return 7'b0011001;
            5:  return 7'b0010010;
            6:  return 7'b0000010;
            7:  return 7'b1111000;
            8:  return 7'b0000000;
            9:  return 7'b0010000;
            10: return 7'b0001000;
            11: return 7'b0000011;
            12: return 7'b1000110;
            13: return 7'b0100001;
            14: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    typedef struct packed {
        logic [NUM_CH-1:0] ch;
        logic [6:0]        ssd;
    } beat_t;

    beat_t sb[$];

    // Monitor: every payload beat must match the queue head; during clkPB
    // gaps the count must stay at the head's value.
    beat_t mon_beat;
    always @(negedge clock) begin
        #2;
        if (reset && SerOutValid) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", 32'(SerOutValid), 32'd0);
            end else if (clkPB) begin
                mon_beat = sb.pop_front();
                check("data_ch", 32'(ch_out), 32'(mon_beat.ch));
                check("data_ssd", 32'(ssd_result), 32'(mon_beat.ssd));
            end else begin
                check("gap_ssd", 32'(ssd_result), 32'(sb[0].ssd));
            end
        end
    end

    // Called at a falling edge: present one bit for one enabled edge, then
    // hold clkPB low for gap cycles. Returns at a falling edge.
    task automatic drive_bit(input logic b, input int gap);
        SerIn = b;
        clkPB = 1'b1;
        @(negedge clock);
        clkPB = 1'b0;
        repeat (gap) @(negedge clock);
    endtask

    // Send a frame; payload bit i (transmission order) is pl[i]. A
    // stop_after >= 0 abandons the frame after that many payload bits.
    task automatic send_frame(input int a, input int l, input logic [14:0] pl,
                              input int gap, input int stop_after, input bit flip);
        logic       p;
        logic [3:0] v;
        p = 1'b0;
        for (int i = 0; i < l; i++) begin
            v    = '0;
            v[a] = pl[i];
            sb.push_back('{ch: v, ssd: seg_of(l - i)});
        end
        drive_bit(1'b0, gap);
        for (int i = ADDR_W - 1; i >= 0; i--) begin
            p ^= 1'(a >> i);
            drive_bit(1'(a >> i), gap);
        end
        for (int i = LEN_W - 1; i >= 0; i--) begin
            p ^= 1'(l >> i);
            drive_bit(1'(l >> i), gap);
        end
        for (int i = 0; i < l; i++) begin
            if (i == stop_after) return;
            p ^= pl[i];
            drive_bit(pl[i], gap);
        end
`ifdef PARITY_EN
        drive_bit(p ^ flip, gap);
`else
        if (flip) p = ~p;
`endif
    endtask

    // Called at a falling edge just after the last frame bit.
    task automatic check_done(input int a, input bit exp_perr);
        #2;
        check("done", 32'(done), 32'd1);
        check("done_valid", 32'(SerOutValid), 32'd0);
        check("done_ch", 32'(ch_out), 32'd0);
        check("ch_sel", 32'(ch_sel), 32'(a));
        check("done_ssd", 32'(ssd_result), 32'(seg_of(0)));
        check("done_busy", 32'(busy), 32'd1);
        check("sb_drained", 32'(sb.size()), 32'd0);
`ifdef PARITY_EN
        check("parity_err", 32'(parity_err), 32'(exp_perr));
`else
        if (exp_perr) check("parity_unexpected", 32'(done), 32'd0);
`endif
        @(negedge clock);
        drive_bit(1'b1, 0);
        #2;
        check("idle_done", 32'(done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
`ifdef PARITY_EN
        check("idle_perr", 32'(parity_err), 32'd0);
`endif
        sb.delete();
        @(negedge clock);
    endtask

    initial begin
        int          ra;
        int          rl;
        int          rg;
        logic [14:0] rp;

        // Reset state
        repeat (3) @(negedge clock);
        #2;
        check("rst_ch", 32'(ch_out), 32'd0);
        check("rst_valid", 32'(SerOutValid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ch_sel", 32'(ch_sel), 32'd0);
        check("rst_ssd", 32'(ssd_result), 32'(7'b1000000));
        @(negedge clock);
        reset = 1'b1;

        // Start bit present but never strobed: must stay idle.
        SerIn = 1'b0;
        clkPB = 1'b0;
        repeat (4) @(negedge clock);
        #2;
        check("no_strobe_busy", 32'(busy), 32'd0);
        @(negedge clock);

        // addr=2, len=3, payload 1,0,1 with continuous strobes
        send_frame(2, 3, 15'b101, 0, -1, 1'b0);
        check_done(2, 1'b0);

        // Same frame, 5 idle cycles between every bit
        send_frame(2, 3, 15'b101, 5, -1, 1'b0);
        check_done(2, 1'b0);

        // Empty payload
        send_frame(1, 0, 15'd0, 0, -1, 1'b0);
        check_done(1, 1'b0);

        // Maximum payload to the top channel
        send_frame(3, 15, 15'h2D6B, 0, -1, 1'b0);
        check_done(3, 1'b0);

        // Reset during DATA after 2 of 7 payload bits
        send_frame(1, 7, 15'h55, 0, 2, 1'b0);
        #3;
        reset = 1'b0;
        #1;
        check("mid_rst_ch", 32'(ch_out), 32'd0);
        check("mid_rst_valid", 32'(SerOutValid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ssd", 32'(ssd_result), 32'(seg_of(0)));
        sb.delete();
        @(negedge clock);
        reset = 1'b1;
        repeat (4) drive_bit(1'b1, 0);
        #2;
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_ch_sel", 32'(ch_sel), 32'd0);
        @(negedge clock);

        // A few random frames
        for (int k = 0; k < 4; k++) begin
            ra = int'($urandom_range(0, 3));
            rl = int'($urandom_range(1, 15));
            rg = int'($urandom_range(0, 2));
            rp = 15'($urandom);
            send_frame(ra, rl, rp, rg, -1, 1'b0);
            check_done(ra, 1'b0);
        end

`ifdef PARITY_EN
        // Corrupted parity bit
        send_frame(2, 3, 15'b101, 0, -1, 1'b1);
        check_done(2, 1'b1);
        send_frame(0, 0, 15'd0, 1, -1, 1'b1);
        check_done(0, 1'b1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Backstop so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
